// File: rtl/idx_pkg.sv
// Shared definitions for the nested-loop index counter bank.
// State encoding, default geometry and the digit-select width helper.
package idx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int W_DEF   = 6;
    localparam int NCH_DEF = 2;

    // Digit select needs at least one bit even for a single-digit bank.
    function automatic int sel_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/idx_counter_bank_if.sv
// Control/status bundle between the core FSM and the index counter bank.
// The bank drives the slave side; the controller drives the master side.
interface idx_counter_bank_if #(
    parameter int W   = idx_pkg::W_DEF,
    parameter int NCH = idx_pkg::NCH_DEF
);
    localparam int SW = idx_pkg::sel_w(NCH);

    logic             start_i;
    logic             clr_i;
    logic             adv_i;
    logic             ld_en_i;
    logic [SW-1:0]    ld_sel_i;
    logic [W-1:0]     ld_val_i;
    logic [NCH*W-1:0] limit_i;
    logic [NCH*W-1:0] idx_o;
    logic [NCH-1:0]   wrap_o;
    logic             last_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  start_i, clr_i, adv_i, ld_en_i, ld_sel_i, ld_val_i, limit_i,
        output idx_o, wrap_o, last_o, busy_o, done_o
    );

    modport master (
        output start_i, clr_i, adv_i, ld_en_i, ld_sel_i, ld_val_i, limit_i,
        input  idx_o, wrap_o, last_o, busy_o, done_o
    );
endinterface

// File: rtl/idx_digit.sv
// One index digit: clear, saturating load and increment-on-carry with wrap at limit.
// Next value registered in one cycle; no backpressure, acts on the cycle's controls.
module idx_digit
    import idx_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         ld_en,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] limit,
    input  logic         cin,
    output logic [W-1:0] idx,
    output logic         at_limit,
    output logic         carry_out
);

    logic [W-1:0] idx_q, idx_d;

    assign at_limit  = (idx_q == limit);
    assign carry_out = cin & at_limit;
    assign idx       = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (ld_en) begin
            idx_d = (ld_val > limit) ? limit : ld_val;
        end else if (cin) begin
            // idx_q never exceeds limit, so the increment cannot overflow.
            idx_d = at_limit ? '0 : idx_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/idx_counter_bank.sv
// Nested-loop index generator: NCH chained digits stepped by adv_i, done pulse on final tuple.
// One tuple per cycle with adv_i held; clr_i > ld_en_i > adv_i; wrap/last are registered-state only.
module idx_counter_bank
    import idx_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int NCH = NCH_DEF
) (
    input logic               clk,
    input logic               rstn,
    idx_counter_bank_if.slave bus
);

    state_e           state_q, state_d;
    logic [NCH*W-1:0] lim_q, lim_d;
    logic             done_q, done_d;
    logic             clr_all;
    logic             ld_any;
    logic             step;

    logic [NCH*W-1:0] idx;
    logic [NCH-1:0]   at_lim;
    logic [NCH-1:0]   wrap;
    logic [NCH-1:0]   cin;
    logic [NCH-1:0]   cout;
    logic             unused_cout_top;

    assign unused_cout_top = cout[NCH-1];

    for (genvar k = 0; k < NCH; k++) begin : g_dig
        logic ld_k;
        // Selects at or above NCH never match a digit and are dropped.
        assign ld_k = ld_any && (int'(bus.ld_sel_i) == k);

        if (k == 0) begin : g_c0
            assign cin[k] = step;
        end else begin : g_cn
            assign cin[k] = cout[k-1];
        end

        idx_digit #(.W(W)) u_dig (
            .clk       (clk),
            .rstn      (rstn),
            .clr       (clr_all),
            .ld_en     (ld_k),
            .ld_val    (bus.ld_val_i),
            .limit     (lim_q[k*W +: W]),
            .cin       (cin[k]),
            .idx       (idx[k*W +: W]),
            .at_limit  (at_lim[k]),
            .carry_out (cout[k])
        );
    end

    always_comb begin
        wrap[0] = at_lim[0];
        for (int k = 1; k < NCH; k++) begin
            wrap[k] = wrap[k-1] & at_lim[k];
        end
    end

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        done_d  = 1'b0;
        clr_all = 1'b0;
        ld_any  = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i && !bus.clr_i) begin
                    lim_d   = bus.limit_i;
                    clr_all = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clr_i) begin
                    clr_all = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.ld_en_i) begin
                    ld_any = 1'b1;
                end else if (bus.adv_i) begin
                    if (wrap[NCH-1]) begin
                        clr_all = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            lim_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            done_q  <= done_d;
        end
    end

    assign bus.idx_o  = idx;
    assign bus.wrap_o = wrap;
    assign bus.last_o = wrap[NCH-1];
    assign bus.busy_o = (state_q == ST_RUN);
    assign bus.done_o = done_q;

endmodule

// File: doc/idx_counter_bank.md
# idx_counter_bank

Parametrised nested-loop index generator. It replaces the single 6-bit x-index register with a bank of NCH chained index digits (x, y, channel, ...), each with a programmable limit, load, clear and carry. It sits between the core control FSM and the memory address generators. It steps the multi-dimensional index tuple on an advance handshake and flags the final tuple with a one-cycle done pulse.

## Interface
- W, 6: width of each index digit and its limit.
- NCH, 2: number of chained digits. Digit 0 is the innermost (fastest).
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  begin a scan. Sampled only in IDLE.
- clr_i  in  1  synchronous abort. Highest synchronous priority.
- adv_i  in  1  advance the index tuple by one. Sampled only in RUN.
- ld_en_i  in  1  direct write of one digit. Sampled only in RUN.
- ld_sel_i  in  $clog2(NCH) (min 1)  digit selected for load.
- ld_val_i  in  W  load value.
- limit_i  in  NCH*W  per-digit inclusive maximum. Digit k is bits [k*W +: W]. Latched at start.
- idx_o  out  NCH*W  current index tuple, same packing as limit_i.
- wrap_o  out  NCH  bit k = 1 when digit k and every lower digit sit at their limits, i.e. the next advance carries out of k.
- last_o  out  1  = wrap_o[NCH-1]. The current tuple is the final one.
- busy_o  out  1  state is RUN.
- done_o  out  1  one-cycle pulse at scan completion.

## Operation
- States: IDLE and RUN.
- Reset (async, rstn=0): state IDLE; all idx digits 0; latched limits 0; done_o 0; busy_o 0. wrap_o and last_o follow from the zero state (all 1s, since idx = limit = 0).
- IDLE:
  - start_i=1 and clr_i=0: latch limit_i, zero all digits, go to RUN.
  - adv_i and ld_en_i are ignored.
- RUN, priority per cycle: clr_i > ld_en_i > adv_i.
  - clr_i: go to IDLE, zero all digits, no done pulse.
  - ld_en_i: digit ld_sel_i <= min(ld_val_i, limit[ld_sel_i]). Other digits hold. adv_i is ignored that cycle. ld_sel_i >= NCH is ignored.
  - adv_i with last_o=0: digit 0 increments. Any digit equal to its limit whose lower digits all carry resets to 0 and carries into the next digit. Digits above the carry chain hold.
  - adv_i with last_o=1: all digits go to 0, state goes to IDLE, done_o pulses.
  - start_i in RUN is ignored.
- Width and arithmetic:
  - Digits never exceed their latched limit, so the W-bit increment cannot overflow.
  - A limit of 0 makes that digit wrap on every carry into it.
  - limit_i changes during RUN have no effect.
- wrap_o and last_o are combinational from registered idx and latched limits only. They have no input-to-output path.

## Timing
- start_i at edge n: busy_o=1 and idx_o=0 from edge n+1 onward.
- adv_i at edge n: new idx_o visible after edge n. Throughput is one tuple per cycle with adv_i held high.
- Final adv_i at edge n: after edge n, done_o=1 for exactly one cycle, busy_o=0 and idx_o=0. start_i in the done cycle is accepted (back-to-back scans).
- clr_i at edge n: IDLE and zero after edge n.
- Loaded values are visible one cycle after ld_en_i.
- Full scan length = product over k of (limit_k+1) advances.
- rstn deassertion: first state change possible at the first clk edge after rstn is high.

## Structure
- Shared package idx_pkg:
  - state encoding (IDLE=1'b0, RUN=1'b1);
  - default W and NCH constants;
  - the helper for the ld_sel_i width (max(1,$clog2(NCH))).
- Sub-module idx_digit, instantiated NCH times via generate. Each instance holds one W-bit index register with async active-low reset, clear, saturating load, and increment-on-carry-in. It outputs at_limit and carry_out.
- The top level holds the FSM, the limit latch and the carry chain.

## Test plan
- W=6, NCH=2, limits x=3, y=2; start, adv_i held high → idx (y,x) steps (0,0),(0,1)…(0,3),(1,0)…(2,3) in 12 cycles; wrap_o[0]=1 at every x=3; done_o pulses once after the 12th advance; busy_o falls in the same cycle.
- Same limits, adv_i toggled 1,0,0,1 → idx holds during the 0 cycles; total advances to done is still 12.
- clr_i asserted at (1,2) together with adv_i → next cycle IDLE, idx (0,0), done_o never asserts.
- Load tests (limits x=3, y=2):
  - ld_sel_i=0, ld_val_i=9 → x=3 (saturated);
  - then ld_sel_i=1, ld_val_i=2 → last_o=1;
  - ld_en_i and adv_i in the same cycle → load taken, no advance;
  - then one adv_i → done_o.
- Edge cases:
  - limits all 0: start then first adv_i → done_o.
  - start_i and clr_i in the same IDLE cycle → stays IDLE.
  - start_i in the done cycle → busy_o next cycle.
- rstn pulled low mid-scan at (2,1) → idx_o 0, busy_o 0, done_o 0 immediately without a clock edge; start after release begins a fresh scan.
